// File: rtl/or_chk_pkg.sv
// Shared types and helpers for the OR-gate response checker.
package or_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } or_vec_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // The settle counter must hold the value SETTLE, and it must be at least one bit wide.
  function automatic int unsigned settle_cnt_w(input int unsigned s);
    return (clog2(s + 1) == 0) ? 1 : clog2(s + 1);
  endfunction

endpackage

// File: rtl/or_response_checker_if.sv
// Stimulus and result bundle between an OR-gate environment and its response checker.
interface or_response_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             enable;
  logic             clear;
  logic             a_in;
  logic             b_in;
  logic             c_in;
  logic             chk_pulse;
  logic             chk_fail;
  logic [CNT_W-1:0] check_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_flag;
  logic [2:0]       first_err_vec;
  logic [3:0]       seen_mask;
  logic             all_covered;

  modport master (
    output enable, clear, a_in, b_in, c_in,
    input  chk_pulse, chk_fail, check_cnt, err_cnt, err_flag,
           first_err_vec, seen_mask, all_covered
  );

  modport slave (
    input  enable, clear, a_in, b_in, c_in,
    output chk_pulse, chk_fail, check_cnt, err_cnt, err_flag,
           first_err_vec, seen_mask, all_covered
  );
endinterface

// File: rtl/or_chk_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module or_chk_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/or_response_checker.sv
// Monitors a 2-input OR gate: checks c == a|b once inputs have been stable for SETTLE cycles.
module or_response_checker
  import or_chk_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst,
  or_response_checker_if.slave bus
);
  localparam int unsigned SW = settle_cnt_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
  localparam state_e AFTER_CAPTURE = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

  state_e     state_q, state_d;
  logic       a_q, a_d, b_q, b_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic       do_chk, mis, in_chg;
  logic       chk_pulse_q, chk_fail_q;
  logic       err_flag_q, err_flag_d;
  or_vec_t    first_err_vec_q, first_err_vec_d;
  logic [3:0] seen_mask_q, seen_mask_d;
  logic [CNT_W-1:0] check_cnt, err_cnt;

  assign in_chg = {bus.a_in, bus.b_in} != {a_q, b_q};
  assign mis    = bus.c_in != (a_q | b_q);

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    cnt_d           = cnt_q;
    do_chk          = 1'b0;
    err_flag_d      = err_flag_q;
    first_err_vec_d = first_err_vec_q;
    seen_mask_d     = seen_mask_q;
    if (bus.clear) begin
      state_d         = ST_IDLE;
      a_d             = 1'b0;
      b_d             = 1'b0;
      cnt_d           = '0;
      err_flag_d      = 1'b0;
      first_err_vec_d = '0;
      seen_mask_d     = '0;
    end else if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          cnt_d   = SETTLE_LD;
          state_d = AFTER_CAPTURE;
        end
        ST_SETTLE: begin
          // Any input movement restarts the full settle window.
          if (in_chg) begin
            a_d   = bus.a_in;
            b_d   = bus.b_in;
            cnt_d = SETTLE_LD;
          end else if (cnt_q == SW'(1)) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          do_chk                 = 1'b1;
          seen_mask_d[{a_q, b_q}] = 1'b1;
          if (mis) begin
            err_flag_d = 1'b1;
            if (!err_flag_q) first_err_vec_d = '{a: a_q, b: b_q, c: bus.c_in};
          end
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (in_chg) begin
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            cnt_d   = SETTLE_LD;
            state_d = AFTER_CAPTURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      a_q             <= 1'b0;
      b_q             <= 1'b0;
      cnt_q           <= '0;
      chk_pulse_q     <= 1'b0;
      chk_fail_q      <= 1'b0;
      err_flag_q      <= 1'b0;
      first_err_vec_q <= '0;
      seen_mask_q     <= '0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      cnt_q           <= cnt_d;
      chk_pulse_q     <= do_chk;
      chk_fail_q      <= do_chk & mis;
      err_flag_q      <= err_flag_d;
      first_err_vec_q <= first_err_vec_d;
      seen_mask_q     <= seen_mask_d;
    end
  end

  or_chk_sat_counter #(.W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (do_chk),
    .clr_i (bus.clear),
    .cnt_o (check_cnt)
  );

  or_chk_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (do_chk & mis),
    .clr_i (bus.clear),
    .cnt_o (err_cnt)
  );

  assign bus.chk_pulse     = chk_pulse_q;
  assign bus.chk_fail      = chk_fail_q;
  assign bus.check_cnt     = check_cnt;
  assign bus.err_cnt       = err_cnt;
  assign bus.err_flag      = err_flag_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.seen_mask     = seen_mask_q;
  assign bus.all_covered   = &seen_mask_q;
endmodule

// File: tb/tb_or_response_checker.sv
// Directed-vector bench for or_response_checker: SETTLE=2/CNT_W=16 and SETTLE=0/CNT_W=3 instances.
module tb_or_response_checker;
  import or_chk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned pulses0 = 0;
  int unsigned pulses1 = 0;
  int unsigned p;

  or_response_checker_if #(.CNT_W(16)) bus0 ();
  or_response_checker_if #(.CNT_W(3))  bus1 ();

  or_response_checker #(.CNT_W(16), .SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  or_response_checker #(.CNT_W(3),  .SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.chk_pulse) pulses0++;
    if (bus1.chk_pulse) pulses1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic a, input logic b, input logic c);
    bus0.a_in = a;
    bus0.b_in = b;
    bus0.c_in = c;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    bus1.a_in = a;
    bus1.b_in = b;
    bus1.c_in = c;
  endtask

  logic [1:0] v1 [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
  logic [1:0] v4 [9] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [1:0] v;

  initial begin
    rst = 1'b1;
    bus0.enable = 1'b0; bus0.clear = 1'b0; drive0(1'b0, 1'b0, 1'b0);
    bus1.enable = 1'b0; bus1.clear = 1'b0; drive1(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("rst_check_cnt", 32'(bus0.check_cnt), 32'd0);
    check_eq("rst_err_cnt",   32'(bus0.err_cnt), 32'd0);
    check_eq("rst_err_flag",  32'(bus0.err_flag), 32'd0);
    check_eq("rst_fev",       32'(bus0.first_err_vec), 32'd0);
    check_eq("rst_seen",      32'(bus0.seen_mask), 32'd0);
    check_eq("rst_pulse",     32'(bus0.chk_pulse), 32'd0);
    check_eq("rst_cov",       32'(bus0.all_covered), 32'd0);
    ticks(2);
    rst = 1'b0;

    // 1: full coverage, all correct
    p = pulses0;
    bus0.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = v1[i];
      drive0(v[1], v[0], v[1] | v[0]);
      ticks(15);
    end
    check_eq("t1_check_cnt", 32'(bus0.check_cnt), 32'd4);
    check_eq("t1_err_cnt",   32'(bus0.err_cnt), 32'd0);
    check_eq("t1_seen",      32'(bus0.seen_mask), 32'hf);
    check_eq("t1_cov",       32'(bus0.all_covered), 32'd1);
    check_eq("t1_pulses",    pulses0 - p, 32'd4);
    check_eq("t1_err_flag",  32'(bus0.err_flag), 32'd0);

    // 2: first error latched, second error does not overwrite
    drive0(1'b1, 1'b1, 1'b0);
    ticks(4);
    check_eq("t2_pulse",     32'(bus0.chk_pulse), 32'd1);
    check_eq("t2_fail",      32'(bus0.chk_fail), 32'd1);
    check_eq("t2_err_cnt",   32'(bus0.err_cnt), 32'd1);
    check_eq("t2_err_flag",  32'(bus0.err_flag), 32'd1);
    check_eq("t2_fev",       32'(bus0.first_err_vec), 32'(3'b110));
    check_eq("t2_check_cnt", 32'(bus0.check_cnt), 32'd5);
    ticks(10);
    drive0(1'b0, 1'b1, 1'b0);
    ticks(4);
    check_eq("t2b_fail",     32'(bus0.chk_fail), 32'd1);
    check_eq("t2b_err_cnt",  32'(bus0.err_cnt), 32'd2);
    check_eq("t2b_fev",      32'(bus0.first_err_vec), 32'(3'b110));
    check_eq("t2b_check",    32'(bus0.check_cnt), 32'd6);

    // 3: clear, then glitch during settle restarts the window
    bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;
    check_eq("clr_check_cnt", 32'(bus0.check_cnt), 32'd0);
    check_eq("clr_err_flag",  32'(bus0.err_flag), 32'd0);
    check_eq("clr_fev",       32'(bus0.first_err_vec), 32'd0);
    check_eq("clr_seen",      32'(bus0.seen_mask), 32'd0);
    drive0(1'b0, 1'b1, 1'b1);
    tick();
    drive0(1'b0, 1'b0, 1'b0);
    p = pulses0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_no_pulse", 32'(bus0.chk_pulse), 32'd0);
    end
    tick();
    check_eq("t3_pulse",     32'(bus0.chk_pulse), 32'd1);
    check_eq("t3_fail",      32'(bus0.chk_fail), 32'd0);
    check_eq("t3_check_cnt", 32'(bus0.check_cnt), 32'd1);
    check_eq("t3_seen",      32'(bus0.seen_mask), 32'(4'b0001));
    ticks(8);
    check_eq("t3_pulses",    pulses0 - p, 32'd1);

    // enable drop mid-settle: no check, results retained
    drive0(1'b1, 1'b1, 1'b1);
    tick();
    bus0.enable = 1'b0;
    p = pulses0;
    ticks(6);
    check_eq("en_no_pulse",  pulses0 - p, 32'd0);
    check_eq("en_check_cnt", 32'(bus0.check_cnt), 32'd1);
    bus0.enable = 1'b1;
    ticks(4);
    check_eq("en_pulse",     32'(bus0.chk_pulse), 32'd1);
    check_eq("en_check_cnt2", 32'(bus0.check_cnt), 32'd2);
    check_eq("en_seen",      32'(bus0.seen_mask), 32'(4'b1001));

    // 5: reset mid-settle
    drive0(1'b0, 1'b1, 1'b1);
    ticks(2);
    rst = 1'b1;
    #1;
    check_eq("t5_check_cnt", 32'(bus0.check_cnt), 32'd0);
    check_eq("t5_seen",      32'(bus0.seen_mask), 32'd0);
    check_eq("t5_pulse",     32'(bus0.chk_pulse), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_no_pulse", 32'(bus0.chk_pulse), 32'd0);
    end
    tick();
    check_eq("t5_pulse2",    32'(bus0.chk_pulse), 32'd1);
    check_eq("t5_check_cnt2", 32'(bus0.check_cnt), 32'd1);
    check_eq("t5_seen2",     32'(bus0.seen_mask), 32'(4'b0010));

    // 6: clear coincident with a failing CHECK
    drive0(1'b1, 1'b0, 1'b0);
    ticks(3);
    bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;
    check_eq("t6_pulse",     32'(bus0.chk_pulse), 32'd0);
    check_eq("t6_check_cnt", 32'(bus0.check_cnt), 32'd0);
    check_eq("t6_err_cnt",   32'(bus0.err_cnt), 32'd0);
    check_eq("t6_err_flag",  32'(bus0.err_flag), 32'd0);
    check_eq("t6_state",     32'(dut0.state_q), 32'(ST_IDLE));
    ticks(4);
    check_eq("t6_fail2",     32'(bus0.chk_fail), 32'd1);
    check_eq("t6_err_cnt2",  32'(bus0.err_cnt), 32'd1);
    check_eq("t6_fev2",      32'(bus0.first_err_vec), 32'(3'b100));

    // 4: CNT_W=3 saturation, SETTLE=0
    bus1.enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      v = v4[i];
      drive1(v[1], v[0], 1'b0);
      ticks(2);
      check_eq("t4_pulse", 32'(bus1.chk_pulse), 32'd1);
      check_eq("t4_check_cnt", 32'(bus1.check_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      tick();
    end
    check_eq("t4_err_cnt",  32'(bus1.err_cnt), 32'd7);
    check_eq("t4_err_flag", 32'(bus1.err_flag), 32'd1);
    check_eq("t4_fev",      32'(bus1.first_err_vec), 32'(3'b010));
    check_eq("t4_cov",      32'(bus1.all_covered), 32'd1);
    check_eq("t4_pulses",   pulses1, 32'd9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
